fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch datapath. It owns the PC, issues requests to a stall-capable instruction memory, tracks one outstanding request, and squashes stale returns on branch/jump redirect. Fetched instructions are buffered in a small FIFO and handed to decode over a valid/ready handshake. It also handles halt and memory-error shutdown.

---
 rtl/fetch_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the PC and issues one read at a time to a stall-capable memory.
// Returns that went stale because of a redirect are squashed. Fetched words
// are buffered in a DEPTH-entry FIFO and handed to decode over valid/ready.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_cnt/stall_cnt outputs.
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        halt,
   output logic        mem_rd,
   output logic [15:0] mem_addr,
   input  logic        mem_stall,
   input  logic        mem_done,
   input  logic [15:0] mem_data,
   input  logic        mem_err,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] pc2,
   input  logic        instr_ready,
   output logic        err,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] fetch_cnt,
   output logic [15:0] stall_cnt
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} state_t;

   state_t                  state_q, state_d;
   logic [15:0]             pc_q, pc_d;
   logic [15:0]             req_pc_q, req_pc_d;
   logic                    outst_q, outst_d;
   logic                    squash_q, squash_d;
   logic                    halt_pend_q, halt_pend_d;
   logic                    err_q, err_d;
   logic [CW-1:0]           count_q, count_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [DEPTH-1:0][31:0]  buf_q, buf_d;     // {instr, pc+2} per entry

   logic room, accept, done_v, push, pop, flush;

   // A request may only go out if the buffer can absorb its return; that is
   // what keeps a push from ever meeting a full FIFO.
   assign room     = ({1'b0, count_q} + {{CW{1'b0}}, outst_q}) < {1'b0, FULL};
   assign mem_rd   = (state_q == REQ) && room && !halt && !halt_pend_q;
   assign mem_addr = mem_rd ? pc_q : 16'h0000;
   assign accept   = mem_rd && !mem_stall;
   // mem_done with nothing outstanding is noise and is ignored.
   assign done_v   = mem_done && outst_q;

   assign instr_valid = (count_q != '0);
   assign pop         = instr_valid && instr_ready;
   assign instr       = instr_valid ? buf_q[rd_ptr_q][31:16] : 16'h0000;
   assign pc2         = instr_valid ? buf_q[rd_ptr_q][15:0]  : 16'h0000;
   assign err         = err_q;
   assign halted      = (state_q == HALTED);

   // Next-state: fetch sequencing, return handling, redirect override.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      outst_d     = outst_q;
      squash_d    = squash_q;
      err_d       = err_q;
      halt_pend_d = halt_pend_q;
      push        = 1'b0;
      flush       = 1'b0;

      if (state_q != HALTED) halt_pend_d = halt_pend_q | halt;

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            // Nothing is outstanding here, so a halt can stop us at once.
            if (halt || halt_pend_q) begin
               state_d = HALTED;
            end else if (accept) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 16'd2;
               outst_d  = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (done_v) begin
               outst_d = 1'b0;
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = halt_pend_d ? HALTED : REQ;
               end else if (mem_err) begin
                  err_d   = 1'b1;
                  state_d = HALTED;
               end else begin
                  push    = 1'b1;
                  state_d = halt_pend_d ? HALTED : REQ;
               end
            end
         end
         HALTED: state_d = HALTED;
         default: state_d = IDLE;
      endcase

      // Redirect wins over everything except HALTED. A return landing in the
      // same cycle belongs to the old path: drop it (error included) and do
      // not arm the squash, since nothing stale is left in flight.
      if (redirect && (state_q != HALTED)) begin
         pc_d  = redirect_pc;
         flush = 1'b1;
         push  = 1'b0;
         err_d = err_q;
         if (done_v) begin
            outst_d  = 1'b0;
            squash_d = 1'b0;
            state_d  = REQ;
         end else if (outst_q) begin
            squash_d = 1'b1;
            state_d  = WAIT;
         end else if (accept) begin
            req_pc_d = pc_q;
            outst_d  = 1'b1;
            squash_d = 1'b1;
            state_d  = WAIT;
         end else begin
            state_d  = REQ;
         end
      end
   end

   // Instruction buffer: circular FIFO, flushed wholesale on redirect.
   always_comb begin
      buf_d    = buf_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            buf_d[wr_ptr_q] = {mem_data, req_pc_q + 16'd2};
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_pc_q    <= 16'h0000;
         outst_q     <= 1'b0;
         squash_q    <= 1'b0;
         halt_pend_q <= 1'b0;
         err_q       <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         buf_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         outst_q     <= outst_d;
         squash_q    <= squash_d;
         halt_pend_q <= halt_pend_d;
         err_q       <= err_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         buf_q       <= buf_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        stall_cyc;

   // A REQ cycle is lost either to a memory stall or to a full buffer.
   assign stall_cyc = (state_q == REQ) && ((mem_rd && mem_stall) || (count_q == FULL));

   // Saturating performance counters.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (push && (fetch_cnt_q != 16'hFFFF))      fetch_cnt_d = fetch_cnt_q + 16'd1;
      if (stall_cyc && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q <= 16'h0000;
         stall_cnt_q <= 16'h0000;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized traffic for fetch_ctrl,
// checked every cycle against a transaction-level model (PC, one in-flight
// tag, a queue for the buffer).
module tb_fetch_ctrl;
   localparam logic [15:0] RESET_PC = 16'h0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst, redirect, halt, mem_stall, mem_done, mem_err, instr_ready;
   logic [15:0] redirect_pc, mem_data, mem_addr, instr, pc2;
   logic        mem_rd, instr_valid, err, halted;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .halt(halt), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_stall(mem_stall),
      .mem_done(mem_done), .mem_data(mem_data), .mem_err(mem_err),
      .instr_valid(instr_valid), .instr(instr), .pc2(pc2),
      .instr_ready(instr_ready), .err(err), .halted(halted));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // stimulus for the next cycle
   logic        n_rst, n_redirect, n_halt, n_stall, n_ready;
   logic [15:0] n_rpc;
   logic        spur_en = 1'b0, err_rand = 1'b0, err_next = 1'b0;
   int          lat_lo = 1, lat_hi = 1;

   // memory responder
   logic        p_pend = 1'b0, p_err = 1'b0;
   int          p_cnt = 0;
   logic [15:0] p_addr = 16'h0;

   // reference model
   logic        m_started, m_stopped, m_busy, m_drop, m_hp, m_err;
   logic [15:0] m_pc, m_tag;
   logic [31:0] m_q[$];

   // observation logs
   logic [15:0] acc_log[$];
   logic [31:0] pop_log[$];
   int          rd0_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] acc_at(input int i);
      return (i < acc_log.size()) ? {16'h0, acc_log[i]} : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] pop_at(input int i);
      return (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic model_reset();
      m_started = 0; m_stopped = 0; m_busy = 0; m_drop = 0; m_hp = 0; m_err = 0;
      m_pc = RESET_PC; m_tag = 16'h0; m_q.delete();
      p_pend = 0;
   endtask

   task automatic tick();
      logic        e_rd, acc, ret, pop_e, hp_n;
      logic [15:0] e_addr, e_instr, e_pc2;
      @(negedge clk);
      rst = n_rst; redirect = n_redirect; redirect_pc = n_rpc; halt = n_halt;
      mem_stall = n_stall; instr_ready = n_ready;
      mem_err = 1'b0; mem_data = 16'($urandom);
      if (p_pend && p_cnt == 0) begin
         mem_done = 1'b1; mem_data = p_addr ^ 16'hA5A5; mem_err = p_err;
      end else if (!p_pend && spur_en && $urandom_range(0, 7) == 0) begin
         mem_done = 1'b1; mem_err = 1'($urandom_range(0, 1));
      end else begin
         mem_done = 1'b0;
      end
      #1;
      if (!rst) model_reset();
      e_rd    = m_started && !m_stopped && !m_busy && (m_q.size() < DEPTH) && !halt && !m_hp;
      e_addr  = e_rd ? m_pc : 16'h0;
      e_instr = (m_q.size() > 0) ? m_q[0][31:16] : 16'h0;
      e_pc2   = (m_q.size() > 0) ? m_q[0][15:0]  : 16'h0;
      chk("mem_rd",      {31'h0, mem_rd},      {31'h0, e_rd});
      chk("mem_addr",    {16'h0, mem_addr},    {16'h0, e_addr});
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, (m_q.size() > 0)});
      chk("instr",       {16'h0, instr},       {16'h0, e_instr});
      chk("pc2",         {16'h0, pc2},         {16'h0, e_pc2});
      chk("err",         {31'h0, err},         {31'h0, m_err});
      chk("halted",      {31'h0, halted},      {31'h0, m_stopped});
      if (mem_rd && !mem_stall) acc_log.push_back(mem_addr);
      if (instr_valid && instr_ready) pop_log.push_back({instr, pc2});
      if (mem_rd && mem_addr == 16'h0) rd0_cnt++;
      cyc++;
      if (rst) begin
         acc   = e_rd && !mem_stall;
         ret   = mem_done && m_busy;
         pop_e = (m_q.size() > 0) && instr_ready;
         // memory side: one request in flight at most
         if (acc) begin
            p_pend = 1; p_cnt = $urandom_range(lat_lo, lat_hi) - 1; p_addr = m_pc;
            p_err = err_next || (err_rand && $urandom_range(0, 39) == 0);
            err_next = 0;
         end else if (p_pend) begin
            if (p_cnt == 0) p_pend = 0; else p_cnt--;
         end
         // controller rules
         if (!m_started) begin
            m_started = 1;
            m_hp = m_hp | halt;
            if (redirect) m_pc = redirect_pc;
         end else if (m_stopped) begin
            if (pop_e) void'(m_q.pop_front());
         end else begin
            hp_n = m_hp | halt;
            if (redirect) begin
               m_q.delete();
               if (ret) begin m_busy = 0; m_drop = 0; end
               else if (m_busy) m_drop = 1;
               else if (acc) begin m_busy = 1; m_drop = 1; m_tag = m_pc; end
               m_pc = redirect_pc;
            end else begin
               if (pop_e) void'(m_q.pop_front());
               if (m_busy) begin
                  if (ret) begin
                     m_busy = 0;
                     if (m_drop) begin m_drop = 0; m_stopped = hp_n; end
                     else if (mem_err) begin m_err = 1; m_stopped = 1; end
                     else begin m_q.push_back({mem_data, m_tag + 16'd2}); m_stopped = hp_n; end
                  end
               end else if (halt || m_hp) begin
                  m_stopped = 1;
               end else if (acc) begin
                  m_tag = m_pc; m_pc = m_pc + 16'd2; m_busy = 1;
               end
            end
            m_hp = hp_n;
         end
      end
   endtask

   task automatic do_reset();
      n_rst = 0; n_redirect = 0; n_halt = 0; n_stall = 0; n_ready = 1; n_rpc = 16'h0;
      repeat (2) tick();
      acc_log.delete(); pop_log.delete(); rd0_cnt = 0;
      n_rst = 1;
   endtask

   task automatic wait_acc(input int n, input int budget);
      int k = 0;
      while (acc_log.size() < n && k < budget) begin tick(); k++; end
      chk("wait_acc", {31'h0, (acc_log.size() >= n)}, 32'd1);
   endtask

   task automatic async_pulse();
      #2; rst = 1'b0; n_rst = 0; #1;
      chk("arst_mem_rd",   {31'h0, mem_rd},      32'd0);
      chk("arst_mem_addr", {16'h0, mem_addr},    32'd0);
      chk("arst_valid",    {31'h0, instr_valid}, 32'd0);
      chk("arst_instr",    {16'h0, instr},       32'd0);
      chk("arst_pc2",      {16'h0, pc2},         32'd0);
      chk("arst_err",      {31'h0, err},         32'd0);
      chk("arst_halted",   {31'h0, halted},      32'd0);
      model_reset();
   endtask

   initial begin
      int fv, ps, idx;
      rst = 0; redirect = 0; redirect_pc = 0; halt = 0; mem_stall = 0;
      mem_done = 0; mem_data = 0; mem_err = 0; instr_ready = 0;
      model_reset();

      // basic stream, single-cycle memory
      do_reset();
      tick();
      fv = -1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (instr_valid && fv < 0) fv = i;
      end
      chk("first_valid_lat", 32'(fv), 32'd3);
      repeat (4) tick();
      chk("addr0", acc_at(0), 32'h0000);
      chk("addr1", acc_at(1), 32'h0002);
      chk("addr2", acc_at(2), 32'h0004);
      chk("pop0",  pop_at(0), 32'hA5A5_0002);
      chk("pop1",  pop_at(1), 32'hA5A7_0004);
      chk("pop2",  pop_at(2), 32'hA5A1_0006);

      // first request stalled three cycles
      do_reset();
      n_stall = 1;
      repeat (4) tick();
      n_stall = 0;
      repeat (8) tick();
      chk("stall_hold", 32'(rd0_cnt), 32'd4);
      chk("stall_addr0", acc_at(0), 32'h0000);
      chk("stall_addr1", acc_at(1), 32'h0002);
      chk("stall_pop0",  pop_at(0), 32'hA5A5_0002);

      // decode back-pressure fills the buffer
      do_reset();
      n_ready = 0;
      repeat (10) tick();
      chk("bp_acc_cnt", 32'(acc_log.size()), 32'd2);
      chk("bp_no_rd",   {31'h0, mem_rd}, 32'd0);
      chk("bp_valid",   {31'h0, instr_valid}, 32'd1);
      n_ready = 1;
      repeat (6) tick();
      chk("bp_pop0",  pop_at(0), 32'hA5A5_0002);
      chk("bp_pop1",  pop_at(1), 32'hA5A7_0004);
      chk("bp_addr2", acc_at(2), 32'h0004);

      // redirect while the 0004 fetch is in flight
      do_reset();
      lat_lo = 3; lat_hi = 3;
      wait_acc(3, 40);
      n_redirect = 1; n_rpc = 16'h0100;
      tick();
      n_redirect = 0;
      ps = pop_log.size();
      repeat (15) tick();
      chk("redir_addr", acc_at(3), 32'h0100);
      chk("redir_pop",  pop_at(ps), 32'hA4A5_0102);

      // halt while waiting: the in-flight word still arrives
      do_reset();
      lat_lo = 2; lat_hi = 2;
      wait_acc(2, 40);
      n_halt = 1;
      repeat (8) tick();
      n_halt = 0;
      chk("halt_halted", {31'h0, halted}, 32'd1);
      chk("halt_last",   pop_at(pop_log.size() - 1), 32'hA5A7_0004);
      chk("halt_acc",    32'(acc_log.size()), 32'd2);
      n_redirect = 1; n_rpc = 16'h0200;
      tick();
      n_redirect = 0;
      repeat (4) tick();
      chk("halt_redir_acc", 32'(acc_log.size()), 32'd2);
      chk("halt_sticky",    {31'h0, halted}, 32'd1);

      // access fault on the first return
      lat_lo = 1; lat_hi = 1;
      do_reset();
      err_next = 1;
      repeat (8) tick();
      chk("merr_err",    {31'h0, err}, 32'd1);
      chk("merr_halted", {31'h0, halted}, 32'd1);
      chk("merr_pops",   32'(pop_log.size()), 32'd0);
      chk("merr_acc",    32'(acc_log.size()), 32'd1);

      // async reset mid-wait, then PC wrap
      do_reset();
      lat_lo = 3; lat_hi = 3;
      tick();
      wait_acc(1, 20);
      tick();
      async_pulse();
      tick();
      n_rst = 1;
      acc_log.delete();
      repeat (6) tick();
      chk("restart_addr", acc_at(0), {16'h0, RESET_PC});
      lat_lo = 1; lat_hi = 1;
      n_redirect = 1; n_rpc = 16'hFFFE;
      tick();
      n_redirect = 0;
      repeat (14) tick();
      idx = -1;
      for (int i = 0; i < acc_log.size(); i++) if (acc_log[i] == 16'hFFFE && idx < 0) idx = i;
      chk("wrap_seen", {31'h0, (idx >= 0)}, 32'd1);
      chk("wrap_next", acc_at(idx + 1), 32'h0000);

      // randomized traffic
      spur_en = 1; err_rand = 1; lat_lo = 1; lat_hi = 3;
      for (int s = 0; s < 8; s++) begin
         do_reset();
         for (int i = 0; i < 350; i++) begin
            n_redirect = ($urandom_range(0, 11) == 0);
            n_rpc      = 16'($urandom_range(0, 32767) * 2);
            n_stall    = ($urandom_range(0, 3) == 0);
            n_ready    = ($urandom_range(0, 3) != 0);
            n_halt     = ($urandom_range(0, 199) == 0);
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
